// File: rtl/aquarium_pkg.sv
// aquarium_pkg: shared sequencer states, display mux codes, channel ids and per-channel limits.
package aquarium_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CHECK, S_SHOW, S_ERROR} state_t;

    localparam logic [4:0] MODE_IDLE = 5'b00000;
    localparam logic [4:0] MODE_CH0  = 5'b00001;
    localparam logic [4:0] MODE_CH1  = 5'b00010;
    localparam logic [4:0] MODE_CH2  = 5'b00100;
    localparam logic [4:0] MODE_CH3  = 5'b01000;
    localparam logic [4:0] MODE_CH4  = 5'b10000;
    localparam logic [4:0] MODE_ERR  = 5'b11111;

    localparam logic [2:0] CH_FISH  = 3'd0;
    localparam logic [2:0] CH_CLEAN = 3'd1;
    localparam logic [2:0] CH_TEMP  = 3'd2;
    localparam logic [2:0] CH_FOOD  = 3'd3;
    localparam logic [2:0] CH_SALT  = 3'd4;

    // Entry n of each table belongs to channel n.
    localparam logic [4:0][7:0] LO = {8'd0, 8'd10, 8'd22, 8'd50, 8'd1};
    localparam logic [4:0][7:0] HI = {8'd40, 8'd255, 8'd28, 8'd255, 8'd30};
    localparam logic [4:0][4:0] MODE_CH = {MODE_CH4, MODE_CH3, MODE_CH2, MODE_CH1, MODE_CH0};

    function automatic logic in_range(input logic [2:0] ch, input logic [7:0] v);
        return (v >= LO[ch]) && (v <= HI[ch]);
    endfunction

    function automatic logic [4:0] ch_mode(input logic [2:0] ch);
        return MODE_CH[ch];
    endfunction
endpackage

// File: rtl/mode_timer.sv
// mode_timer: loadable down-counter that stops at zero; done flags the last cycle of a count.
module mode_timer (
    input  logic       CLK,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= load ? load_val : (done ? cnt_q : cnt_q - 8'd1);
    end

    assign done = (cnt_q == 8'd0);
endmodule

// File: rtl/tank_monitor_sequencer.sv
// tank_monitor_sequencer: scans five tank sensors, limit-checks each reading and
// shows it on the display mux for a fixed dwell, latching the first error seen.
module tank_monitor_sequencer
    import aquarium_pkg::*;
#(
    parameter int DWELL_CYC   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       run,
    input  logic       clear_err,
    input  logic       sens_ack,
    input  logic [7:0] sens_data,
    output logic       sens_req,
    output logic [2:0] sens_sel,
    output logic [4:0] ld_en,
    output logic [4:0] mux_sel,
    output logic [7:0] disp_data,
    output logic       err,
    output logic [2:0] err_src,
    output logic       err_timeout,
    output logic       scan_done
);
    state_t     state_q, state_d;
    logic [2:0] ch_q, ch_d, src_q, src_d;
    logic [7:0] val_q, val_d;
    logic       tmo_q, tmo_d, tmr_done;

    // The timer reloads on every state change: dwell for SHOW, ack budget otherwise.
    mode_timer u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (state_d != state_q),
        .load_val (state_d == S_SHOW ? 8'(DWELL_CYC - 1) : 8'(ACK_TIMEOUT - 1)),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            val_q   <= '0;
            src_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            val_q   <= val_d;
            src_q   <= src_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        val_d     = val_q;
        src_d     = src_q;
        tmo_d     = tmo_q;
        sens_req  = 1'b0;
        ld_en     = '0;
        mux_sel   = MODE_IDLE;
        disp_data = '0;
        err       = 1'b0;
        scan_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                ch_d    = CH_FISH;
                state_d = run ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                sens_req = 1'b1;
                if (sens_ack) begin
                    val_d   = sens_data;
                    ld_en   = ch_mode(ch_q);
                    state_d = S_CHECK;
                end else if (tmr_done) begin
                    src_d   = ch_q;
                    tmo_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_CHECK: begin
                src_d   = in_range(ch_q, val_q) ? src_q : ch_q;
                tmo_d   = in_range(ch_q, val_q) ? tmo_q : 1'b0;
                state_d = in_range(ch_q, val_q) ? S_SHOW : S_ERROR;
            end
            S_SHOW: begin
                mux_sel   = ch_mode(ch_q);
                disp_data = val_q;
                if (tmr_done) begin
                    scan_done = (ch_q == CH_SALT);
                    ch_d      = (!run || ch_q == CH_SALT) ? CH_FISH : ch_q + 3'd1;
                    state_d   = run ? S_REQ : S_IDLE;
                end
            end
            S_ERROR: begin
                mux_sel   = MODE_ERR;
                disp_data = 8'hFF;
                err       = 1'b1;
                if (clear_err) begin
                    ch_d    = CH_FISH;
                    src_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sens_sel    = ch_q;
    assign err_src     = src_q;
    assign err_timeout = tmo_q;
endmodule

// File: tb/tb_tank_monitor_sequencer.sv
// tb_tank_monitor_sequencer: vector table plus directed multi-cycle sequences
// for the tank sensor sequencer at DWELL_CYC=4, ACK_TIMEOUT=8.
module tb_tank_monitor_sequencer;
    logic       CLK = 1'b0;
    logic       reset, run, clear_err, sens_ack;
    logic [7:0] sens_data;
    logic       sens_req, err, err_timeout, scan_done;
    logic [2:0] sens_sel, err_src;
    logic [4:0] ld_en, mux_sel;
    logic [7:0] disp_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic       auto_ack = 1'b0;
    logic       nak_en = 1'b0;
    logic [2:0] nak_ch = 3'd0;
    logic [7:0] dat [8];

    tank_monitor_sequencer #(.DWELL_CYC(4), .ACK_TIMEOUT(8)) dut (
        .CLK(CLK), .reset(reset), .run(run), .clear_err(clear_err),
        .sens_ack(sens_ack), .sens_data(sens_data), .sens_req(sens_req),
        .sens_sel(sens_sel), .ld_en(ld_en), .mux_sel(mux_sel),
        .disp_data(disp_data), .err(err), .err_src(err_src),
        .err_timeout(err_timeout), .scan_done(scan_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [27:0] pk(input logic req, input logic [4:0] ld, input logic [4:0] mux,
                                       input logic [7:0] disp, input logic e, input logic [2:0] src,
                                       input logic t, input logic sd, input logic [2:0] sel);
        return {req, ld, mux, disp, e, src, t, sd, sel};
    endfunction

    logic [27:0] obs;
    assign obs = pk(sens_req, ld_en, mux_sel, disp_data, err, err_src, err_timeout, scan_done, sens_sel);

    typedef struct {
        logic        run, clr, ack;
        logic [7:0]  data;
        logic [27:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic r, input logic c, input logic a, input logic [7:0] d, input logic [27:0] e);
        vec_t v;
        v.run = r; v.clr = c; v.ack = a; v.data = d; v.exp = e;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Advance one clock; the sensor model answers a request in the same cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        if (auto_ack) begin
            sens_ack  = sens_req && !(nak_en && sens_sel == nak_ch);
            sens_data = dat[sens_sel];
        end
        #1;
    endtask

    task automatic do_reset();
        auto_ack = 1'b0; nak_en = 1'b0;
        reset = 1'b1; run = 1'b0; clear_err = 1'b0; sens_ack = 1'b0; sens_data = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_nominal();
        dat[0] = 8'd5; dat[1] = 8'd60; dat[2] = 8'd25; dat[3] = 8'd20;
        dat[4] = 8'd30; dat[5] = 8'd0; dat[6] = 8'd0; dat[7] = 8'd0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sd_cnt, nreq;
        logic hit;
        do_reset();

        add(0, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd0));
        add(1, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd0));
        add(1, 0, 1, 8'd5,  pk(1, 5'b00001, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd0));
        add(1, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd0));
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 8'd0, pk(0, 5'b00000, 5'b00001, 8'd5, 0, 3'd0, 0, 0, 3'd0));
        add(1, 0, 0, 8'd0,  pk(1, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd1));
        add(1, 0, 1, 8'd60, pk(1, 5'b00010, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd1));
        add(1, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd1));
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 8'd0, pk(0, 5'b00000, 5'b00010, 8'd60, 0, 3'd0, 0, 0, 3'd1));
        add(1, 0, 1, 8'd29, pk(1, 5'b00100, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd2));
        add(1, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd2));
        add(1, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b11111, 8'hFF, 1, 3'd2, 0, 0, 3'd2));
        add(1, 0, 1, 8'd0,  pk(0, 5'b00000, 5'b11111, 8'hFF, 1, 3'd2, 0, 0, 3'd2));
        add(0, 1, 0, 8'd0,  pk(0, 5'b00000, 5'b11111, 8'hFF, 1, 3'd2, 0, 0, 3'd2));
        add(0, 0, 0, 8'd0,  pk(0, 5'b00000, 5'b00000, 8'h00, 0, 3'd0, 0, 0, 3'd0));
        foreach (vt[i]) begin
            run = vt[i].run; clear_err = vt[i].clr; sens_ack = vt[i].ack; sens_data = vt[i].data;
            #1;
            chk($sformatf("vec%0d", i), {4'h0, obs}, {4'h0, vt[i].exp});
            step();
        end

        // Nominal scan: 6 cycles per channel, scan_done only at cycle 30.
        do_reset(); load_nominal(); auto_ack = 1'b1; run = 1'b1;
        step();
        sd_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            int c, p;
            logic [4:0] oh;
            c = (k - 1) / 6; p = (k - 1) % 6;
            oh = 5'd1 << c;
            chk($sformatf("scan_c%0d", k), {ld_en, mux_sel, scan_done},
                {(p == 0) ? oh : 5'd0, (p >= 2) ? oh : 5'd0, k == 30});
            sd_cnt += int'(scan_done);
            step();
        end
        chk("scan_done_count", sd_cnt, 1);
        chk("rescan_req", {sens_req, sens_sel}, {1'b1, 3'd0});
        run = 1'b0;

        // Ack timeout on channel 3.
        do_reset(); load_nominal(); auto_ack = 1'b1; nak_en = 1'b1; nak_ch = 3'd3; run = 1'b1;
        nreq = 0; hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            if (sens_req && sens_sel == 3'd3) nreq++;
            hit = err;
        end
        chk("tmo_reached", hit, 1'b1);
        chk("tmo_req_cycles", nreq, 8);
        chk("tmo_state", {sens_req, mux_sel, err, err_src, err_timeout}, {1'b0, 5'b11111, 1'b1, 3'd3, 1'b1});

        // Inclusive limits at the edges pass a full scan.
        do_reset(); load_nominal();
        dat[0] = 8'd30; dat[1] = 8'd50; dat[2] = 8'd22; dat[3] = 8'd10; dat[4] = 8'd0;
        auto_ack = 1'b1; run = 1'b1;
        sd_cnt = 0; hit = 1'b0;
        for (int i = 0; i < 40 && sd_cnt == 0 && !hit; i++) begin
            step();
            sd_cnt += int'(scan_done);
            hit = err;
        end
        chk("bound_no_err", hit, 1'b0);
        chk("bound_scan_done", sd_cnt, 1);

        // Fish count of zero is below its limit.
        do_reset(); load_nominal(); dat[0] = 8'd0; auto_ack = 1'b1; run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin step(); hit = err; end
        chk("fish0_err", {hit, err_src, err_timeout}, {1'b1, 3'd0, 1'b0});

        // Ack arriving on the last allowed REQ cycle is accepted.
        do_reset(); run = 1'b1;
        step();
        for (int i = 1; i < 8; i++) step();
        sens_ack = 1'b1; sens_data = 8'd15; #1;
        chk("late_ack_ld", {sens_req, ld_en, err}, {1'b1, 5'b00001, 1'b0});
        step();
        sens_ack = 1'b0;
        chk("late_ack_check", {err, sens_req, mux_sel}, {1'b0, 1'b0, 5'b00000});
        step();
        chk("late_ack_show", {err, mux_sel, disp_data}, {1'b0, 5'b00001, 8'd15});
        run = 1'b0;

        // Reset mid-SHOW of channel 1, with run, clear_err and ack all asserted.
        do_reset(); load_nominal(); auto_ack = 1'b1; run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin step(); hit = (mux_sel == 5'b00010); end
        chk("reach_show1", hit, 1'b1);
        step();
        auto_ack = 1'b0; reset = 1'b1; clear_err = 1'b1; sens_ack = 1'b1;
        step();
        reset = 1'b0; clear_err = 1'b0; sens_ack = 1'b0; run = 1'b0; #1;
        chk("rst_show_outs", {4'h0, obs}, 32'h0);
        step();
        chk("rst_show_idle", {4'h0, obs}, 32'h0);

        // Reset while in ERROR clears the latched error.
        do_reset(); load_nominal(); dat[0] = 8'd0; auto_ack = 1'b1; run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin step(); hit = err; end
        reset = 1'b1;
        step();
        reset = 1'b0; run = 1'b0; #1;
        chk("rst_err_outs", {4'h0, obs}, 32'h0);

        // run dropped during channel 2 lets that channel finish, then idles.
        do_reset(); load_nominal(); auto_ack = 1'b1; run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin step(); hit = sens_req && sens_sel == 3'd2; end
        chk("reach_req2", hit, 1'b1);
        run = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("drop_show%0d", i), {mux_sel, disp_data}, {5'b00100, 8'd25});
        end
        step();
        chk("drop_idle", {4'h0, obs}, 32'h0);
        step();
        chk("drop_stay_idle", {sens_req, mux_sel}, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tank_monitor_sequencer.md
TANK_MONITOR_SEQUENCER -- requirements
Module: tank_monitor_sequencer

Interface
REQ-001 Parameter DWELL_CYC, default 8, number of cycles each in-range channel is held on the display mux (legal range 1..255).
REQ-002 Parameter ACK_TIMEOUT, default 16, number of cycles sens_req may wait for sens_ack before a timeout error (legal range 1..255).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  enable for continuous scanning.
REQ-007 clear_err  in  1  acknowledge and exit error mode.
REQ-008 sens_ack  in  1  sensor data-valid handshake.
REQ-009 sens_data  in  8  unsigned sensor reading.
REQ-010 sens_req  out  1  sensor read request.
REQ-011 sens_sel  out  3  channel being read: 0 fish count, 1 cleanliness, 2 temperature, 3 food storage, 4 saltiness.
REQ-012 ld_en  out  5  one-hot load strobe for the external channel registers; bit n loads channel n.
REQ-013 mux_sel  out  5  display mux select code.
REQ-014 disp_data  out  8  value currently shown.
REQ-015 err  out  1  error mode active.
REQ-016 err_src  out  3  channel that caused the error.
REQ-017 err_timeout  out  1  1 = handshake timeout, 0 = limit violation.
REQ-018 scan_done  out  1  one-cycle pulse at the end of a full 5-channel scan.

Function
REQ-019 The states SHALL be IDLE, REQ, CHECK, SHOW and ERROR, and mux_sel SHALL only take the codes 00000, 00001, 00010, 00100, 01000, 10000 and 11111.
REQ-020 In IDLE: mux_sel=00000 and disp_data=0; run=1 SHALL move to REQ with ch=0, so sens_req is high in the next cycle.
REQ-021 In REQ: sens_req=1 and sens_sel=ch; in the cycle sens_ack=1, the block SHALL capture sens_data for ch, pulse ld_en[ch] for that cycle only, and go to CHECK.
REQ-022 If ACK_TIMEOUT consecutive REQ cycles pass without sens_ack, the block SHALL go to ERROR with err_src=ch and err_timeout=1; if ack and timeout fall in the same cycle, ack SHALL win.
REQ-023 sens_ack outside REQ SHALL be ignored.
REQ-024 CHECK SHALL last one cycle and use an unsigned inclusive compare LO[ch] <= value <= HI[ch].
  - Out of range: go to ERROR with err_src=ch and err_timeout=0.
  - In range: go to SHOW.
REQ-025 In SHOW: mux_sel = the one-hot code of ch (ch0 00001 ... ch4 10000) and disp_data = the captured value, held for exactly DWELL_CYC cycles.
REQ-026 At the end of SHOW:
  - If ch<4: ch increments and the block goes to REQ.
  - If ch=4: scan_done pulses for one cycle and ch=0; the block goes to REQ if run=1, else IDLE.
REQ-027 run SHALL be sampled only at the end of SHOW; if run=0 there, the block SHALL go to IDLE with ch=0, and deasserting run mid-channel SHALL not abort that channel.
REQ-028 Per-channel latency with an immediate ack SHALL be DWELL_CYC+2 cycles; a full scan SHALL take 5*(DWELL_CYC+2) cycles.
REQ-029 In ERROR: mux_sel=11111, disp_data=8'hFF, err=1, sens_req=0, and err_src/err_timeout are held.
REQ-030 In ERROR, run SHALL be ignored; clear_err=1 SHALL move to IDLE with err=0 and ch=0, and clear_err outside ERROR SHALL be ignored.

Reset
REQ-031 reset=1 at a clock edge SHALL, in any state including mid-handshake, force IDLE and set:
  - ch=0, with all timers and captured values cleared;
  - sens_req, ld_en, err, err_src, err_timeout and scan_done to 0;
  - mux_sel=00000, sens_sel=0 and disp_data=0.
REQ-032 reset SHALL take priority over run, clear_err and sens_ack.

Structure
REQ-033 Shared package aquarium_pkg SHALL hold:
  - the state enum;
  - the mux_sel codes MODE_IDLE..MODE_ERR;
  - the channel ids;
  - the limit tables LO/HI: fish 1/30, cleanliness 50/255, temperature 22/28, food 10/255, saltiness 0/40.
REQ-034 One sub-module, mode_timer, SHALL be a loadable down-counter with a done flag, shared for the dwell and timeout counts.

Verification (DWELL_CYC=4, ACK_TIMEOUT=8)
REQ-035 Nominal scan: run=1, ack one cycle after each req, data 5,60,25,20,30 -> ld_en 00001..10000 in order, mux_sel walks 00001->10000 with 4 cycles each, scan_done pulses once at cycle 30.
REQ-036 Limit violation: temperature = 29 -> ERROR after CHECK, mux_sel=11111, disp_data=FF, err_src=2, err_timeout=0; clear_err -> IDLE, mux_sel=00000.
REQ-037 Timeout: no ack on channel 3 -> after 8 REQ cycles err=1, err_src=3, err_timeout=1, sens_req=0.
REQ-038 Boundaries: fish=30, salt=0, temp=22 -> all pass; fish=0 -> error src 0; ack on the 8th REQ cycle -> accepted, no error.
REQ-039 Reset mid-SHOW of channel 1 and during ERROR -> next cycle IDLE, all outputs 0, no scan_done; run dropped during channel 2 -> channel 2 finishes its SHOW, then IDLE.
